// File: rtl/modular_remainder_subtractor_pkg.sv
// Shared constants and helpers for the x mod n remainder subtractor.
package modular_remainder_subtractor_pkg;

  localparam int unsigned DEF_REGISTER_SIZE  = 32;
  localparam int unsigned DEF_NUM_BLOCKS_IN  = 128;
  localparam int unsigned DEF_NUM_BLOCKS_OUT = 64;

  typedef logic [DEF_REGISTER_SIZE-1:0] block_t;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    int unsigned w;
    if (n < 32'd1) begin
      w = 32'd1;
    end else begin
      w = $clog2(n + 32'd1);
    end
    return w;
  endfunction

  // Width of an address selecting one of n entries (at least one bit).
  function automatic int unsigned addr_width(input int unsigned n);
    int unsigned w;
    if (n <= 32'd1) begin
      w = 32'd1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/modular_remainder_subtractor_block_buffer_ram.sv
// Simple dual-port RAM with a registered read port; holds the x blocks
// until the matching q*n block arrives. No reset on the array or the read
// register so the storage maps onto block or distributed RAM.
module block_buffer_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic             clk_in,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store one block per enabled cycle.
  always_ff @(posedge clk_in) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: registered read, old contents on a same-address collision.
  always_ff @(posedge clk_in) begin
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/modular_remainder_subtractor.sv
// Block-serial r = x - q*n. x is buffered, q*n streams in afterwards and
// each q*n block is subtracted from the matching x block with a borrow
// chain. The low NUM_BLOCKS_OUT blocks of r are emitted; the upper blocks
// must be zero and there must be no final borrow, otherwise error_out is
// raised together with done_out.
module modular_remainder_subtractor
  import modular_remainder_subtractor_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE  = DEF_REGISTER_SIZE,
  parameter int unsigned NUM_BLOCKS_IN  = DEF_NUM_BLOCKS_IN,
  parameter int unsigned NUM_BLOCKS_OUT = DEF_NUM_BLOCKS_OUT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     x_valid_in,
  input  logic [REGISTER_SIZE-1:0] x_block_in,
  input  logic                     qn_valid_in,
  input  logic [REGISTER_SIZE-1:0] qn_block_in,
  output logic                     valid_out,
  output logic [REGISTER_SIZE-1:0] data_block_out,
  output logic                     done_out,
  output logic                     error_out
);

  localparam int unsigned CW = count_width(NUM_BLOCKS_IN);
  localparam int unsigned AW = addr_width(NUM_BLOCKS_IN);

  localparam logic [CW-1:0] L_N_IN  = CW'(NUM_BLOCKS_IN);
  localparam logic [CW-1:0] L_N_OUT = CW'(NUM_BLOCKS_OUT);
  localparam logic [AW-1:0] L_LAST  = AW'(NUM_BLOCKS_IN - 32'd1);

  // Transaction bookkeeping.
  logic [CW-1:0] r_x_count;
  logic [CW-1:0] r_qn_count;
  logic          r_borrow;
  logic          r_ovf;
  logic          r_order;
  logic          r_upper;

  // Subtract stage: q*n block waiting for its buffered x partner.
  logic                     r_s1_valid;
  logic [AW-1:0]            r_s1_idx;
  logic [REGISTER_SIZE-1:0] r_s1_qn;

  logic [REGISTER_SIZE-1:0] w_rd_data;
  logic [REGISTER_SIZE:0]   w_diff_ext;
  logic [REGISTER_SIZE-1:0] w_diff;
  logic                     w_borrow_next;

  logic w_x_accept;
  logic w_x_drop;
  logic w_qn_accept;
  logic w_order_viol;
  logic w_s1_low;
  logic w_upper_hit;
  logic w_complete;
  logic w_final_error;

  block_buffer_ram #(
    .WIDTH (REGISTER_SIZE),
    .DEPTH (NUM_BLOCKS_IN),
    .AW    (AW)
  ) u_x_buffer (
    .clk_in    (clk_in),
    .i_wr_en   (w_x_accept),
    .i_wr_addr (r_x_count[AW-1:0]),
    .i_wr_data (x_block_in),
    .i_rd_en   (w_qn_accept),
    .i_rd_addr (r_qn_count[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  // Input acceptance decode for both streams.
  always_comb begin
    w_x_accept   = 1'b0;
    w_x_drop     = 1'b0;
    w_qn_accept  = 1'b0;
    w_order_viol = 1'b0;
    if (x_valid_in) begin
      if (r_x_count < L_N_IN) begin
        w_x_accept = 1'b1;
      end else begin
        w_x_drop = 1'b1;
      end
    end else begin
      w_x_accept = 1'b0;
      w_x_drop   = 1'b0;
    end
    if (qn_valid_in && (r_qn_count < L_N_IN)) begin
      w_qn_accept = 1'b1;
      // The x write of this same cycle does not count: the read would
      // return the stale entry.
      if (r_qn_count >= r_x_count) begin
        w_order_viol = 1'b1;
      end else begin
        w_order_viol = 1'b0;
      end
    end else begin
      w_qn_accept  = 1'b0;
      w_order_viol = 1'b0;
    end
  end

  // Subtract with borrow and classify the block as emitted or discarded.
  always_comb begin
    w_diff_ext    = {1'b0, w_rd_data} - {1'b0, r_s1_qn}
                    - {{REGISTER_SIZE{1'b0}}, r_borrow};
    w_diff        = w_diff_ext[REGISTER_SIZE-1:0];
    w_borrow_next = w_diff_ext[REGISTER_SIZE];
    w_s1_low      = 1'b0;
    w_upper_hit   = 1'b0;
    w_complete    = 1'b0;
    if (r_s1_valid) begin
      w_s1_low    = (CW'(r_s1_idx) < L_N_OUT);
      w_upper_hit = (!w_s1_low) && (w_diff != {REGISTER_SIZE{1'b0}});
      w_complete  = (r_s1_idx == L_LAST);
    end else begin
      w_s1_low    = 1'b0;
      w_upper_hit = 1'b0;
      w_complete  = 1'b0;
    end
    w_final_error = r_ovf | w_x_drop | r_order | r_upper | w_upper_hit
                    | w_borrow_next;
  end

  // Counters, borrow chain and sticky flags; all clear on completion.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x_count  <= {CW{1'b0}};
      r_qn_count <= {CW{1'b0}};
      r_borrow   <= 1'b0;
      r_ovf      <= 1'b0;
      r_order    <= 1'b0;
      r_upper    <= 1'b0;
    end else if (w_complete) begin
      r_x_count  <= {CW{1'b0}};
      r_qn_count <= {CW{1'b0}};
      r_borrow   <= 1'b0;
      r_ovf      <= 1'b0;
      r_order    <= 1'b0;
      r_upper    <= 1'b0;
    end else begin
      if (w_x_accept) begin
        r_x_count <= r_x_count + CW'(1);
      end
      if (w_x_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_qn_accept) begin
        r_qn_count <= r_qn_count + CW'(1);
      end
      if (w_order_viol) begin
        r_order <= 1'b1;
      end
      if (r_s1_valid) begin
        r_borrow <= w_borrow_next;
      end
      if (w_upper_hit) begin
        r_upper <= 1'b1;
      end
    end
  end

  // Carry the q*n block and its index alongside the RAM read.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= {AW{1'b0}};
      r_s1_qn    <= {REGISTER_SIZE{1'b0}};
    end else begin
      r_s1_valid <= w_qn_accept;
      if (w_qn_accept) begin
        r_s1_idx <= r_qn_count[AW-1:0];
        r_s1_qn  <= qn_block_in;
      end
    end
  end

  // Registered outputs: low blocks of r, completion pulse and verdict.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out      <= 1'b0;
      data_block_out <= {REGISTER_SIZE{1'b0}};
      done_out       <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      valid_out <= w_s1_low;
      if (w_s1_low) begin
        data_block_out <= w_diff;
      end
      done_out  <= w_complete;
      error_out <= w_complete & w_final_error;
    end
  end

endmodule
